// File: rtl/pcie_rst_sequencer_if.sv
// rtl/pcie_rst_sequencer_if.sv - PERST#/link-up inputs and reset/status outputs of the reset sequencer
interface pcie_rst_sequencer_if;
    logic       perst_n_in;
    logic       user_lnk_up;
    logic       core_rst;
    logic       user_rst;
    logic [2:0] rst_state;
    logic       lnk_timeout;
    logic [7:0] perst_drop_cnt;

    modport master (
        output perst_n_in,
        output user_lnk_up,
        input  core_rst,
        input  user_rst,
        input  rst_state,
        input  lnk_timeout,
        input  perst_drop_cnt
    );

    modport slave (
        input  perst_n_in,
        input  user_lnk_up,
        output core_rst,
        output user_rst,
        output rst_state,
        output lnk_timeout,
        output perst_drop_cnt
    );
endinterface

// File: rtl/pcie_rst_sequencer.sv
// rtl/pcie_rst_sequencer.sv - debounced, staged PCIe core/user reset sequencer with link-up timeout
module pcie_rst_sequencer #(
    parameter int    SYNC_STAGES               = 2,
    parameter int    DEBOUNCE_CYCLES           = 16,
    parameter int    CORE_DELAY_CYCLES         = 64,
    parameter int    LNK_TIMEOUT_CYCLES        = 4096,
    parameter string PL_SIM_FAST_LINK_TRAINING = "FALSE"
) (
    input  logic                  clk_int,
    input  logic                  sys_rst,
    pcie_rst_sequencer_if.slave   bus
);
    localparam bit FAST      = (PL_SIM_FAST_LINK_TRAINING == "TRUE");
    localparam int DEB_EFF   = FAST ? 4 : DEBOUNCE_CYCLES;
    localparam int CORE_EFF  = FAST ? 4 : CORE_DELAY_CYCLES;
    localparam int MAX_A     = (DEB_EFF > CORE_EFF) ? DEB_EFF : CORE_EFF;
    localparam int MAX_CYC   = (MAX_A > LNK_TIMEOUT_CYCLES) ? MAX_A : LNK_TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_EFF - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_EFF - 1);
    localparam logic [CNT_W-1:0] LNK_LAST  = CNT_W'(LNK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_CORE_REL = 3'd2,
        ST_WAIT_LNK = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   core_rst_q, core_rst_d;
    logic                   user_rst_q, user_rst_d;
    logic                   lnk_timeout_q, lnk_timeout_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   perst_s;

    assign perst_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.perst_n_in};
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_rst_d    = core_rst_q;
        user_rst_d    = user_rst_q;
        lnk_timeout_d = 1'b0;
        drop_cnt_d    = drop_cnt_q;

        // A PERST# assertion outranks every other transition once sequencing has begun
        if (state_q != ST_HOLD && !perst_s) begin
            state_d    = ST_HOLD;
            cnt_d      = '0;
            core_rst_d = 1'b1;
            user_rst_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    cnt_d      = '0;
                    core_rst_d = 1'b1;
                    user_rst_d = 1'b1;
                    if (perst_s) begin
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_CORE_REL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CORE_REL: begin
                    if (cnt_q == CORE_LAST) begin
                        state_d    = ST_WAIT_LNK;
                        cnt_d      = '0;
                        core_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LNK: begin
                    if (bus.user_lnk_up) begin
                        state_d    = ST_RUN;
                        user_rst_d = 1'b0;
                    end else if (cnt_q == LNK_LAST) begin
                        state_d       = ST_HOLD;
                        cnt_d         = '0;
                        core_rst_d    = 1'b1;
                        lnk_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus.user_lnk_up) begin
                        state_d    = ST_WAIT_LNK;
                        cnt_d      = '0;
                        user_rst_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    core_rst_d = 1'b1;
                    user_rst_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_int) begin
        if (sys_rst) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            core_rst_q    <= 1'b1;
            user_rst_q    <= 1'b1;
            lnk_timeout_q <= 1'b0;
            drop_cnt_q    <= 8'd0;
            sync_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_rst_q    <= core_rst_d;
            user_rst_q    <= user_rst_d;
            lnk_timeout_q <= lnk_timeout_d;
            drop_cnt_q    <= drop_cnt_d;
            sync_q        <= sync_d;
        end
    end

    assign bus.core_rst       = core_rst_q;
    assign bus.user_rst       = user_rst_q;
    assign bus.rst_state      = state_q;
    assign bus.lnk_timeout    = lnk_timeout_q;
    assign bus.perst_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_pcie_rst_sequencer.sv
// tb/tb_pcie_rst_sequencer.sv - bench for pcie_rst_sequencer (default and fast-sim instances)
module tb_pcie_rst_sequencer;
    logic clk_int = 1'b0;
    logic sys_rst = 1'b1;
    logic perst_n = 1'b0;
    logic lnk_up  = 1'b0;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk_int = ~clk_int;

    pcie_rst_sequencer_if bus_a ();
    pcie_rst_sequencer_if bus_b ();

    assign bus_a.perst_n_in  = perst_n;
    assign bus_a.user_lnk_up = lnk_up;
    assign bus_b.perst_n_in  = perst_n;
    assign bus_b.user_lnk_up = lnk_up;

    pcie_rst_sequencer #(
        .LNK_TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk_int (clk_int),
        .sys_rst (sys_rst),
        .bus     (bus_a.slave)
    );

    pcie_rst_sequencer #(
        .LNK_TIMEOUT_CYCLES       (16),
        .PL_SIM_FAST_LINK_TRAINING("TRUE")
    ) dut_b (
        .clk_int (clk_int),
        .sys_rst (sys_rst),
        .bus     (bus_b.slave)
    );

    // Reference model: the sequence is a timeline measured from the start of debounce
    int m_deb  [2] = '{16, 4};
    int m_core [2] = '{64, 4};
    int m_lnk  [2] = '{8, 16};
    int m_sync [2] = '{2, 2};
    bit m_active [2];
    bit m_run    [2];
    int m_age    [2];
    int m_wait   [2];
    int m_drops  [2];
    bit m_to     [2];
    bit m_sh     [2][4];

    function automatic int m_state(int k);
        if (!m_active[k])                  return 0;
        if (m_age[k] < m_deb[k])           return 1;
        if (m_age[k] < m_deb[k] + m_core[k]) return 2;
        if (m_run[k])                      return 4;
        return 3;
    endfunction

    task automatic model_step(int k, bit rst, bit pn, bit lk);
        int s;
        bit ps;
        s = m_state(k);
        m_to[k] = 1'b0;
        if (rst) begin
            m_active[k] = 1'b0;
            m_run[k]    = 1'b0;
            m_age[k]    = 0;
            m_wait[k]   = 0;
            m_drops[k]  = 0;
            for (int i = 0; i < 4; i++) m_sh[k][i] = 1'b0;
            return;
        end
        ps = m_sh[k][m_sync[k]-1];
        for (int i = 3; i > 0; i--) m_sh[k][i] = m_sh[k][i-1];
        m_sh[k][0] = pn;
        if (s != 0 && !ps) begin
            m_active[k] = 1'b0;
            m_run[k]    = 1'b0;
            if (m_drops[k] < 255) m_drops[k]++;
        end else begin
            case (s)
                0: if (ps) begin
                    m_active[k] = 1'b1;
                    m_age[k]    = 0;
                    m_run[k]    = 1'b0;
                end
                1, 2: begin
                    m_age[k]++;
                    if (m_age[k] == m_deb[k] + m_core[k]) m_wait[k] = 0;
                end
                3: begin
                    if (lk) m_run[k] = 1'b1;
                    else if (m_wait[k] == m_lnk[k] - 1) begin
                        m_active[k] = 1'b0;
                        m_to[k]     = 1'b1;
                    end else m_wait[k]++;
                end
                default: if (!lk) begin
                    m_run[k]  = 1'b0;
                    m_wait[k] = 0;
                end
            endcase
        end
    endtask

    task automatic chk(string tag, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, actual, expected, edge_n);
        end
    endtask

    task automatic check_inst(string p, int st, int cr, int ur, int to, int dc, int k);
        int s;
        s = m_state(k);
        chk({p, "_state"}, st, s);
        chk({p, "_core_rst"}, cr, (s < 3) ? 1 : 0);
        chk({p, "_user_rst"}, ur, (s != 4) ? 1 : 0);
        chk({p, "_lnk_timeout"}, to, int'(m_to[k]));
        chk({p, "_drop_cnt"}, dc, m_drops[k]);
    endtask

    task automatic tick();
        @(posedge clk_int);
        for (int k = 0; k < 2; k++) model_step(k, sys_rst, perst_n, lnk_up);
        @(negedge clk_int);
        edge_n++;
        check_inst("a", int'(bus_a.rst_state), int'(bus_a.core_rst), int'(bus_a.user_rst),
                   int'(bus_a.lnk_timeout), int'(bus_a.perst_drop_cnt), 0);
        check_inst("b", int'(bus_b.rst_state), int'(bus_b.core_rst), int'(bus_b.user_rst),
                   int'(bus_b.lnk_timeout), int'(bus_b.perst_drop_cnt), 1);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        perst_n = 1'b0;
        lnk_up  = 1'b0;
        repeat (2) tick();
        sys_rst = 1'b0;
    endtask

    task automatic wait_state_a(int st, int budget, string tag);
        int n;
        n = 0;
        while (int'(bus_a.rst_state) != st && n < budget) begin
            tick();
            n++;
        end
        chk(tag, int'(bus_a.rst_state), st);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ev1, ev2, ev3, evc, evt, evr, evb, pulses, n;

        @(negedge clk_int);
        repeat (4) tick();
        chk("rst_state", int'(bus_a.rst_state), 0);
        chk("rst_core_rst", int'(bus_a.core_rst), 1);
        chk("rst_user_rst", int'(bus_a.user_rst), 1);
        chk("rst_lnk_timeout", int'(bus_a.lnk_timeout), 0);
        chk("rst_drop_cnt", int'(bus_a.perst_drop_cnt), 0);

        // Power-up latency and link-up timeout with no link
        sys_rst = 1'b0;
        perst_n = 1'b1;
        edge_n  = 0;
        ev1 = -1; ev2 = -1; ev3 = -1; evc = -1; evt = -1; evr = -1; evb = -1; pulses = 0;
        repeat (100) begin
            tick();
            if (ev1 < 0 && bus_a.rst_state == 3'd1) ev1 = edge_n;
            if (ev2 < 0 && bus_a.rst_state == 3'd2) ev2 = edge_n;
            if (ev3 < 0 && bus_a.rst_state == 3'd3) ev3 = edge_n;
            if (evc < 0 && !bus_a.core_rst) evc = edge_n;
            if (bus_a.lnk_timeout) begin
                pulses++;
                if (evt < 0) evt = edge_n;
            end
            if (evt >= 0 && evr < 0 && edge_n > evt && bus_a.rst_state == 3'd1) evr = edge_n;
            if (evb < 0 && !bus_b.core_rst) evb = edge_n;
        end
        chk("lat_debounce", ev1, 3);
        chk("lat_core_rel", ev2, 19);
        chk("lat_wait_lnk", ev3, 83);
        chk("lat_core_fall", evc, 83);
        chk("lat_timeout", evt, 91);
        chk("timeout_pulses", pulses, 1);
        chk("lat_restart", evr, 92);
        chk("fast_core_fall", evb, 11);

        // Glitch during debounce
        do_reset();
        perst_n = 1'b1;
        repeat (5) tick();
        perst_n = 1'b0;
        n = 0;
        while (bus_a.rst_state != 3'd0 && n < 10) begin
            tick();
            n++;
        end
        chk("glitch_edges", n, 3);
        chk("glitch_drop_cnt", int'(bus_a.perst_drop_cnt), 1);

        // Link-up, link loss, link-up on the last timeout edge
        do_reset();
        perst_n = 1'b1;
        wait_state_a(3, 200, "reach_wait_lnk");
        lnk_up = 1'b1;
        tick();
        chk("lnk_up_state", int'(bus_a.rst_state), 4);
        chk("lnk_up_user_rst", int'(bus_a.user_rst), 0);
        lnk_up = 1'b0;
        tick();
        chk("lnk_down_state", int'(bus_a.rst_state), 3);
        chk("lnk_down_user_rst", int'(bus_a.user_rst), 1);
        chk("lnk_down_core_rst", int'(bus_a.core_rst), 0);
        repeat (7) tick();
        lnk_up = 1'b1;
        tick();
        chk("late_lnk_state", int'(bus_a.rst_state), 4);
        chk("late_lnk_timeout", int'(bus_a.lnk_timeout), 0);

        // PERST# in RUN, then saturation of the drop counter
        perst_n = 1'b0;
        repeat (2) tick();
        chk("run_drop_pre", int'(bus_a.rst_state), 4);
        tick();
        chk("run_drop_state", int'(bus_a.rst_state), 0);
        chk("run_drop_core_rst", int'(bus_a.core_rst), 1);
        chk("run_drop_user_rst", int'(bus_a.user_rst), 1);
        repeat (300) begin
            perst_n = 1'b1;
            repeat (4) tick();
            perst_n = 1'b0;
            repeat (3) tick();
        end
        chk("drop_saturate", int'(bus_a.perst_drop_cnt), 255);

        // sys_rst while running
        perst_n = 1'b1;
        lnk_up  = 1'b1;
        wait_state_a(4, 200, "reach_run");
        sys_rst = 1'b1;
        tick();
        chk("sysrst_state", int'(bus_a.rst_state), 0);
        chk("sysrst_core_rst", int'(bus_a.core_rst), 1);
        chk("sysrst_user_rst", int'(bus_a.user_rst), 1);
        chk("sysrst_drop_cnt", int'(bus_a.perst_drop_cnt), 0);
        sys_rst = 1'b0;

        // Random traffic against the model
        repeat (6000) begin
            if (perst_n) perst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            else         perst_n = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 14) == 0) lnk_up = ~lnk_up;
            sys_rst = ($urandom_range(0, 1999) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
